roi_expand_axis: RTL
====================

Name: roi_expand_axis

Overview:
Inverse of the ROI crop path. Takes the small-area pixel stream, an AXI-Stream subset with backpressure, and re-expands it into a full WIDTH x HEIGHT raster frame. ROI pixels are placed at their rectangle coordinates and every pixel outside the rectangle is filled with a constant. It sits downstream of the crop/processing chain and feeds display or frame-sink logic that expects full frames with tlast at frame end.

Parameters:
WIDTH, 800, large-frame width in pixels
HEIGHT, 600, large-frame height in pixels
BIT_D, 8, pixel width
BIT_C, 32, coordinate register width
FILL, 0, BIT_D-wide value output for pixels outside the ROI

Ports:
clk_i  in  1  single clock, rising edge
arst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; begin one output frame
xy_0_i  in  BIT_C  corner 0: x0 = [26:16], y0 = [9:0]
xy_1_i  in  BIT_C  corner 1: x1 = [26:16], y1 = [9:0]
tdata_i  in  BIT_D  small-area pixel
tvalid_i  in  1  small-area pixel valid
tlast_i  in  1  last small-area pixel
tready_o  out  1  small-area pixel accepted this cycle when tvalid_i & tready_o
tdata_o  out  BIT_D  large-frame pixel
tvalid_o  out  1  large-frame pixel valid
tlast_o  out  1  last pixel of large frame
tready_i  in  1  downstream ready
busy_o  out  1  frame in progress
err_o  out  1  sticky: small-stream tlast mismatch

Behaviour:
- Reset (arst_n_i=0, async assert, sync release): state IDLE, counters 0. Outputs: tdata_o=0, tvalid_o=0, tlast_o=0, tready_o=0, busy_o=0, err_o=0. A reset mid-frame abandons the frame with no partial tlast.
- FSM states: IDLE, LOAD, RUN, FLUSH.
- IDLE: waits for start_i, then goes to LOAD. start_i is ignored in any other state.
- LOAD (1 cycle): latches xy_0_i/xy_1_i and clears err_o.
  - xmin = min(x0,x1), xmax = max(x0,x1); same for y. Bounds are inclusive.
  - Values are clamped to WIDTH-1 / HEIGHT-1.
  - Raster counters cnt_x = cnt_y = 0. Next state RUN.
- RUN: raster order, x fastest. in_roi = (xmin<=cnt_x<=xmax) & (ymin<=cnt_y<=ymax).
- Output register: single stage. It loads a new beat when (!tvalid_o | tready_i). tdata_o/tvalid_o/tlast_o are registered; latency is 1 cycle from acceptance to output.
- Outside the ROI: the beat is FILL and always loadable; tready_o=0.
- Inside the ROI: tready_o = load_ok & in_roi (combinational). The beat loads only when tvalid_i & tready_o. If tvalid_i=0, the counter holds and no beat loads (bubble on tvalid_o).
- Counter advance: on each loaded beat, cnt_x++. At WIDTH-1, cnt_x wraps to 0 and cnt_y++.
- tlast_o is set on the beat with cnt_x=WIDTH-1 and cnt_y=HEIGHT-1. After loading it, go to FLUSH.
- FLUSH: hold until the final beat handshakes (tvalid_o & tready_i), then go to IDLE.
- busy_o=1 in LOAD/RUN/FLUSH.
- tlast check: on each consumed small beat, expected = (cnt_x==xmax & cnt_y==ymax).
  - If tlast_i != expected, set err_o. It stays set until the next LOAD.
  - Placement always follows coordinates, never tlast_i.
- Output beat count per frame is exactly WIDTH*HEIGHT. Consumed input beats per frame are exactly (xmax-xmin+1)*(ymax-ymin+1).
- Widths: cnt_x is $clog2(WIDTH) bits and cnt_y is $clog2(HEIGHT) bits. Compare against the clamped bounds at the same width.

Decomposition:
- Shared package roi_pkg:
  - state enum type (IDLE, LOAD, RUN, FLUSH)
  - coordinate field constants X_MSB=26, X_LSB=16, Y_MSB=9, Y_LSB=0
  - functions for field extract and clamp
- The crop block imports the same field constants.
- One sub-module: roi_raster_cnt, the x/y raster counter with enable, clear, wrap and last-pixel flag. It is reusable by the crop block.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4.
1. Basic: start_i, xy_0=(2,1), xy_1=(4,2), tready_i=1, input stream 1..6 with tlast on 6 -> 32 output beats. Pixels 1,2,3 at indices 10-12 and 4,5,6 at indices 18-20; all others FILL. tlast_o only on index 31. err_o=0.
2. Swapped and out-of-range corners: xy_0=(9,5), xy_1=(6,2) -> ROI clamps to x 6..7, y 2..3. 4 input beats are consumed and placed at indices 22,23,30,31.
3. Backpressure: tready_i toggles 1/0 each cycle and tvalid_i is randomly gapped -> output sequence is identical to scenario 1. tdata_o/tvalid_o are stable while tvalid_o & !tready_i. tready_o is never high outside the ROI.
4. tlast mismatch: scenario 1 with tlast_i on beat 4 -> err_o rises after beat 4 is consumed and stays 1. The output frame is unchanged. The next start_i clears err_o during LOAD.
5. Full-frame ROI: xy_0=(0,0), xy_1=(7,3) -> 32 input beats pass 1:1 with no FILL and 1-cycle latency; tlast_o is aligned with input beat 32.
6. Reset mid-frame: arst_n_i low at output beat 15 -> tvalid_o, busy_o, tready_o go to 0 asynchronously. After release, start_i gives a clean full 32-beat frame. A start_i pulse while busy_o=1 is ignored.

Source files
------------

// File: rtl/roi_pkg.sv
// Shared definitions for the ROI crop/expand pair: FSM state type,
// coordinate register field positions and small helper functions.
package roi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Corner register layout: x in [26:16], y in [9:0]
  localparam int X_MSB = 26;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 9;
  localparam int Y_LSB = 0;
  localparam int X_W   = X_MSB - X_LSB + 1;
  localparam int Y_W   = Y_MSB - Y_LSB + 1;

  function automatic logic [X_W-1:0] field_x(input logic [31:0] xy);
    return X_W'(xy >> X_LSB);
  endfunction

  function automatic logic [Y_W-1:0] field_y(input logic [31:0] xy);
    return Y_W'(xy >> Y_LSB);
  endfunction

  // Saturate a coordinate to the last valid index of its axis
  function automatic int unsigned clamp(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/roi_raster_cnt.sv
// Raster x/y counter: x runs fastest, wraps at WIDTH-1 and bumps y.
// last_o flags the final pixel of the frame at the current count.
module roi_raster_cnt #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] cnt_x_o,
  output logic [YW-1:0] cnt_y_o,
  output logic          last_o
);

  logic x_end;
  logic y_end;

  assign x_end  = (cnt_x_o == XW'(WIDTH - 1));
  assign y_end  = (cnt_y_o == YW'(HEIGHT - 1));
  assign last_o = x_end & y_end;

  // Advance one pixel per enable; clear has priority
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_x_o <= '0;
      cnt_y_o <= '0;
    end else if (clr_i) begin
      cnt_x_o <= '0;
      cnt_y_o <= '0;
    end else if (en_i) begin
      if (x_end) begin
        cnt_x_o <= '0;
        cnt_y_o <= y_end ? '0 : cnt_y_o + 1'b1;
      end else begin
        cnt_x_o <= cnt_x_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/roi_expand_axis.sv
// Re-expands a cropped ROI pixel stream into a full WIDTH x HEIGHT raster.
// Pixels inside the rectangle come from the input stream, all others are
// FILL. Output is a single registered AXI-Stream stage with tlast at frame end.
module roi_expand_axis
  import roi_pkg::*;
#(
  parameter int               WIDTH  = 800,
  parameter int               HEIGHT = 600,
  parameter int               BIT_D  = 8,
  parameter int               BIT_C  = 32,
  parameter logic [BIT_D-1:0] FILL   = '0
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             start_i,
  input  logic [BIT_C-1:0] xy_0_i,
  input  logic [BIT_C-1:0] xy_1_i,
  input  logic [BIT_D-1:0] tdata_i,
  input  logic             tvalid_i,
  input  logic             tlast_i,
  output logic             tready_o,
  output logic [BIT_D-1:0] tdata_o,
  output logic             tvalid_o,
  output logic             tlast_o,
  input  logic             tready_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t        state;
  logic [XW-1:0] xmin, xmax, cnt_x;
  logic [YW-1:0] ymin, ymax, cnt_y;
  logic          frame_last;
  logic          in_roi;
  logic          load_ok;
  logic          in_acc;
  logic          beat_load;
  logic          roi_end;

  int unsigned   x0c, x1c, y0c, y1c;
  int unsigned   lo_x, hi_x, lo_y, hi_y;

  // Clamp both corners to the frame, then order them into min/max bounds
  always_comb begin
    x0c  = clamp(32'(field_x(32'(xy_0_i))), 32'(WIDTH - 1));
    x1c  = clamp(32'(field_x(32'(xy_1_i))), 32'(WIDTH - 1));
    y0c  = clamp(32'(field_y(32'(xy_0_i))), 32'(HEIGHT - 1));
    y1c  = clamp(32'(field_y(32'(xy_1_i))), 32'(HEIGHT - 1));
    lo_x = (x0c < x1c) ? x0c : x1c;
    hi_x = (x0c < x1c) ? x1c : x0c;
    lo_y = (y0c < y1c) ? y0c : y1c;
    hi_y = (y0c < y1c) ? y1c : y0c;
  end

  roi_raster_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW)
  ) u_cnt (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (state == ST_LOAD),
    .en_i     (beat_load),
    .cnt_x_o  (cnt_x),
    .cnt_y_o  (cnt_y),
    .last_o   (frame_last)
  );

  assign in_roi  = (cnt_x >= xmin) && (cnt_x <= xmax) &&
                   (cnt_y >= ymin) && (cnt_y <= ymax);
  assign roi_end = (cnt_x == xmax) && (cnt_y == ymax);
  // Output register can take a beat when empty or being drained this cycle
  assign load_ok   = !tvalid_o || tready_i;
  assign tready_o  = (state == ST_RUN) && load_ok && in_roi;
  assign in_acc    = tvalid_i && tready_o;
  // Fill beats never wait on the input; ROI beats wait for a handshake
  assign beat_load = (state == ST_RUN) && (in_roi ? in_acc : load_ok);

  // Frame sequencing, bound capture and tlast consistency tracking
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= ST_IDLE;
      busy_o <= 1'b0;
      err_o  <= 1'b0;
      xmin   <= '0;
      xmax   <= '0;
      ymin   <= '0;
      ymax   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state  <= ST_LOAD;
            busy_o <= 1'b1;
          end
        end
        ST_LOAD: begin
          xmin  <= XW'(lo_x);
          xmax  <= XW'(hi_x);
          ymin  <= YW'(lo_y);
          ymax  <= YW'(hi_y);
          err_o <= 1'b0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // Placement ignores tlast_i; a disagreement is only reported
          if (in_acc && (tlast_i != roi_end)) err_o <= 1'b1;
          if (beat_load && frame_last) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (tvalid_o && tready_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single-stage output register with standard valid/ready hold
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tdata_o  <= '0;
      tvalid_o <= 1'b0;
      tlast_o  <= 1'b0;
    end else if (beat_load) begin
      tdata_o  <= in_roi ? tdata_i : FILL;
      tvalid_o <= 1'b1;
      tlast_o  <= frame_last;
    end else if (tready_i) begin
      tvalid_o <= 1'b0;
      tlast_o  <= 1'b0;
    end
  end

endmodule
